// File: rtl/mpu6050_i2c_target_pkg.sv
// Shared definitions for the MPU6050 I2C target: register map, reset values
// and the transfer state encoding.
package mpu6050_i2c_target_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        REG,
        REG_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        MACK
    } state_t;

    localparam logic [7:0] REG_ACCEL_CONFIG  = 8'h1C;
    localparam logic [7:0] REG_ACCEL_XOUT_H  = 8'h3B;
    localparam logic [7:0] REG_ACCEL_XOUT_L  = 8'h3C;
    localparam logic [7:0] REG_ACCEL_YOUT_H  = 8'h3D;
    localparam logic [7:0] REG_ACCEL_YOUT_L  = 8'h3E;
    localparam logic [7:0] REG_ACCEL_ZOUT_H  = 8'h3F;
    localparam logic [7:0] REG_ACCEL_ZOUT_L  = 8'h40;
    localparam logic [7:0] REG_PWR_MGMT_1    = 8'h6B;
    localparam logic [7:0] REG_WHO_AM_I      = 8'h75;

    localparam logic [7:0] PWR_MGMT_1_RST    = 8'h40;
    localparam logic [7:0] ACCEL_CONFIG_RST  = 8'h00;

endpackage

// File: rtl/mpu6050_i2c_target_i2c_bus_sync.sv
// SCL/SDA synchronizers with edge history; emits SCL edge and START/STOP pulses.
module i2c_bus_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_raw,
    input  logic sda_raw,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_pipe;
    logic [SYNC_STAGES-1:0] sda_pipe;
    logic                   scl_d;
    logic                   sda_d;
    logic                   scl;

    // Reset to the idle-bus level so no edge is seen on reset release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_pipe <= '1;
            sda_pipe <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_pipe[0] <= scl_raw;
            sda_pipe[0] <= sda_raw;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                scl_pipe[i] <= scl_pipe[i-1];
                sda_pipe[i] <= sda_pipe[i-1];
            end
            scl_d <= scl;
            sda_d <= sda;
        end
    end

    assign scl       = scl_pipe[SYNC_STAGES-1];
    assign sda       = sda_pipe[SYNC_STAGES-1];
    assign scl_rise  = scl & ~scl_d;
    assign scl_fall  = ~scl & scl_d;
    assign start_det = scl & scl_d & sda_d & ~sda;
    assign stop_det  = scl & scl_d & ~sda_d & sda;

endmodule

// File: rtl/mpu6050_i2c_target.sv
// I2C target emulating the MPU6050 register interface: pointer-based writes,
// burst reads with a coherent accelerometer snapshot.
module mpu6050_i2c_target
    import mpu6050_i2c_target_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR     = 7'h68,
    parameter logic [7:0]  WHO_AM_I_VAL = 8'h68,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic        MCLK,
    input  logic        RESET,
    input  logic        SCL_IN,
    input  logic        SDA_IN,
    output logic        SDA_OE,
    input  logic [15:0] ACC_X,
    input  logic [15:0] ACC_Y,
    input  logic [15:0] ACC_Z,
    output logic [7:0]  PWR_MGMT_1,
    output logic [7:0]  ACCEL_CONFIG,
    output logic        WR_STB,
    output logic        BUSY
);

    logic sda, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (MCLK),
        .rst_n     (RESET),
        .scl_raw   (SCL_IN),
        .sda_raw   (SDA_IN),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    state_t      state, state_n;
    logic [3:0]  bit_cnt, bit_cnt_n;
    logic [7:0]  shift, shift_n;
    logic [7:0]  tx, tx_n;
    logic [7:0]  ptr, ptr_n;
    logic        rw, rw_n;
    logic [47:0] shadow, shadow_n;
    logic        sda_oe_n, busy_n, wr_stb_n;
    logic [7:0]  pwr_n, acfg_n;

    function automatic logic [7:0] reg_byte(input logic [7:0] addr, input logic [47:0] shd);
        logic [7:0] v;
        case (addr)
            REG_ACCEL_XOUT_H: v = shd[47:40];
            REG_ACCEL_XOUT_L: v = shd[39:32];
            REG_ACCEL_YOUT_H: v = shd[31:24];
            REG_ACCEL_YOUT_L: v = shd[23:16];
            REG_ACCEL_ZOUT_H: v = shd[15:8];
            REG_ACCEL_ZOUT_L: v = shd[7:0];
            REG_ACCEL_CONFIG: v = ACCEL_CONFIG;
            REG_PWR_MGMT_1:   v = PWR_MGMT_1;
            REG_WHO_AM_I:     v = WHO_AM_I_VAL;
            default:          v = 8'h00;
        endcase
        return v;
    endfunction

    always_ff @(posedge MCLK) begin
        if (!RESET) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            shift        <= '0;
            tx           <= '0;
            ptr          <= '0;
            rw           <= 1'b0;
            shadow       <= '0;
            SDA_OE       <= 1'b0;
            BUSY         <= 1'b0;
            WR_STB       <= 1'b0;
            PWR_MGMT_1   <= PWR_MGMT_1_RST;
            ACCEL_CONFIG <= ACCEL_CONFIG_RST;
        end else begin
            state        <= state_n;
            bit_cnt      <= bit_cnt_n;
            shift        <= shift_n;
            tx           <= tx_n;
            ptr          <= ptr_n;
            rw           <= rw_n;
            shadow       <= shadow_n;
            SDA_OE       <= sda_oe_n;
            BUSY         <= busy_n;
            WR_STB       <= wr_stb_n;
            PWR_MGMT_1   <= pwr_n;
            ACCEL_CONFIG <= acfg_n;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        tx_n      = tx;
        ptr_n     = ptr;
        rw_n      = rw;
        shadow_n  = shadow;
        sda_oe_n  = SDA_OE;
        busy_n    = BUSY;
        wr_stb_n  = 1'b0;
        pwr_n     = PWR_MGMT_1;
        acfg_n    = ACCEL_CONFIG;

        if (stop_det) begin
            state_n  = IDLE;
            sda_oe_n = 1'b0;
            busy_n   = 1'b0;
        end else if (start_det) begin
            state_n   = ADDR;
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
        end else begin
            case (state)
                IDLE: ;
                ADDR: begin
                    if (scl_rise) begin
                        shift_n   = {shift[6:0], sda};
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        if (shift[7:1] == DEV_ADDR) begin
                            state_n  = ADDR_ACK;
                            sda_oe_n = 1'b1;
                            busy_n   = 1'b1;
                            rw_n     = shift[0];
                        end else begin
                            state_n = IDLE;
                            busy_n  = 1'b0;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_n = '0;
                        if (rw) begin
                            // Snapshot and first-byte lookup share the same
                            // sample so the burst is coherent from byte zero.
                            state_n  = RDATA;
                            shadow_n = {ACC_X, ACC_Y, ACC_Z};
                            tx_n     = reg_byte(ptr, {ACC_X, ACC_Y, ACC_Z});
                            sda_oe_n = ~tx_n[7];
                        end else begin
                            state_n  = REG;
                            sda_oe_n = 1'b0;
                        end
                    end
                end
                REG: begin
                    if (scl_rise) begin
                        shift_n   = {shift[6:0], sda};
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        ptr_n    = shift;
                        sda_oe_n = 1'b1;
                        state_n  = REG_ACK;
                    end
                end
                REG_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_n  = 1'b0;
                        bit_cnt_n = '0;
                        state_n   = WDATA;
                    end
                end
                WDATA: begin
                    if (scl_rise) begin
                        shift_n   = {shift[6:0], sda};
                        bit_cnt_n = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            wr_stb_n = 1'b1;
                            ptr_n    = ptr + 8'd1;
                            if (ptr == REG_PWR_MGMT_1)   pwr_n  = shift_n;
                            if (ptr == REG_ACCEL_CONFIG) acfg_n = shift_n;
                        end
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        sda_oe_n = 1'b1;
                        state_n  = WDATA_ACK;
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_oe_n = 1'b0;
                            ptr_n    = ptr + 8'd1;
                            state_n  = MACK;
                        end else begin
                            tx_n     = {tx[6:0], 1'b0};
                            sda_oe_n = ~tx[6];
                        end
                    end
                end
                MACK: begin
                    if (scl_rise && sda) begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                    end else if (scl_fall) begin
                        state_n   = RDATA;
                        bit_cnt_n = '0;
                        tx_n      = reg_byte(ptr, shadow);
                        sda_oe_n  = ~tx_n[7];
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule
